// File: rtl/alt_vipitc130_is2vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : alt_vipitc130_is2vid_timing_gen
// Purpose  : Video timing generator with double-buffered mode registers.
// Revision : 1.0
// ============================================================================
module alt_vipitc130_is2vid_timing_gen (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        mode_valid,
   output logic        mode_ack,
   input  logic        mode_interlaced,
   input  logic [15:0] mode_h_total_minus_one,
   input  logic [15:0] mode_v_total_minus_one,
   input  logic [15:0] mode_h_blank,
   input  logic [15:0] mode_h_sync_start,
   input  logic [15:0] mode_h_sync_end,
   input  logic [15:0] mode_f2_v_start,
   input  logic [15:0] mode_f1_v_start,
   input  logic [15:0] mode_f1_v_end,
   input  logic [15:0] mode_f2_v_sync_start,
   input  logic [15:0] mode_f2_v_sync_end,
   input  logic [15:0] mode_f1_v_sync_start,
   input  logic [15:0] mode_f1_v_sync_end,
   input  logic [15:0] mode_f_rising_edge,
   input  logic [15:0] mode_f_falling_edge,
   output logic [15:0] h_count,
   output logic [15:0] v_count,
   output logic        h_sync,
   output logic        v_sync,
   output logic        h_blank,
   output logic        v_blank,
   output logic        field,
   output logic        active,
   output logic        sof,
   output logic        running
);

   localparam logic [0:0] ST_STOPPED = 1'b0;
   localparam logic [0:0] ST_RUNNING = 1'b1;

   typedef struct packed {
      logic        interlaced;
      logic [15:0] h_total_minus_one;
      logic [15:0] v_total_minus_one;
      logic [15:0] h_blank;
      logic [15:0] h_sync_start;
      logic [15:0] h_sync_end;
      logic [15:0] f2_v_start;
      logic [15:0] f1_v_start;
      logic [15:0] f1_v_end;
      logic [15:0] f2_v_sync_start;
      logic [15:0] f2_v_sync_end;
      logic [15:0] f1_v_sync_start;
      logic [15:0] f1_v_sync_end;
      logic [15:0] f_rising_edge;
      logic [15:0] f_falling_edge;
   } mode_t;

   // Half-open [a,b); an empty or inverted range never matches.
   function automatic logic in_range(input logic [15:0] x, input logic [15:0] a,
                                     input logic [15:0] b);
      return (x >= a) && (x < b);
   endfunction

   logic [0:0]  r_state;
   mode_t       r_pend;
   mode_t       r_act;
   mode_t       w_new;
   logic        r_pend_valid;
   logic        r_loaded;
   logic [15:0] r_h;
   logic [15:0] r_v;
   logic        w_running;
   logic        w_frame_end;
   logic        w_load;
   logic        w_h_sync;
   logic        w_v_sync;
   logic        w_h_blank;
   logic        w_v_blank;
   logic        w_field;

   assign w_new = '{
      interlaced:        mode_interlaced,
      h_total_minus_one: mode_h_total_minus_one,
      v_total_minus_one: mode_v_total_minus_one,
      h_blank:           mode_h_blank,
      h_sync_start:      mode_h_sync_start,
      h_sync_end:        mode_h_sync_end,
      f2_v_start:        mode_f2_v_start,
      f1_v_start:        mode_f1_v_start,
      f1_v_end:          mode_f1_v_end,
      f2_v_sync_start:   mode_f2_v_sync_start,
      f2_v_sync_end:     mode_f2_v_sync_end,
      f1_v_sync_start:   mode_f1_v_sync_start,
      f1_v_sync_end:     mode_f1_v_sync_end,
      f_rising_edge:     mode_f_rising_edge,
      f_falling_edge:    mode_f_falling_edge
   };

   assign w_running   = (r_state == ST_RUNNING);
   assign w_frame_end = w_running && (r_h == r_act.h_total_minus_one) &&
                        (r_v == r_act.v_total_minus_one);
   assign w_load      = r_pend_valid && (!w_running || w_frame_end);

   // A mode_valid coinciding with a load stays pending; the load takes the older set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend       <= '0;
         r_act        <= '0;
         r_pend_valid <= 1'b0;
         r_loaded     <= 1'b0;
      end else begin
         if (mode_valid)
            r_pend <= w_new;
         if (w_load) begin
            r_act    <= r_pend;
            r_loaded <= 1'b1;
         end
         r_pend_valid <= mode_valid | (r_pend_valid & ~w_load);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_STOPPED;
         r_h     <= 16'd0;
         r_v     <= 16'd0;
      end else begin
         case (r_state)
            ST_STOPPED: begin
               r_h <= 16'd0;
               r_v <= 16'd0;
               if (enable && r_loaded)
                  r_state <= ST_RUNNING;
            end
            ST_RUNNING: begin
               if (w_frame_end && !enable) begin
                  r_state <= ST_STOPPED;
                  r_h     <= 16'd0;
                  r_v     <= 16'd0;
               end else if (r_h == r_act.h_total_minus_one) begin
                  r_h <= 16'd0;
                  r_v <= (r_v == r_act.v_total_minus_one) ? 16'd0 : r_v + 16'd1;
               end else begin
                  r_h <= r_h + 16'd1;
               end
            end
            default: begin
               r_state <= ST_STOPPED;
               r_h     <= 16'd0;
               r_v     <= 16'd0;
            end
         endcase
      end
   end

   assign w_h_blank = (r_h < r_act.h_blank);
   assign w_h_sync  = in_range(r_h, r_act.h_sync_start, r_act.h_sync_end);
   assign w_v_blank = (r_v >= r_act.f2_v_start) ||
                      (r_act.interlaced && in_range(r_v, r_act.f1_v_start, r_act.f1_v_end));
   assign w_v_sync  = in_range(r_v, r_act.f2_v_sync_start, r_act.f2_v_sync_end) ||
                      (r_act.interlaced &&
                       in_range(r_v, r_act.f1_v_sync_start, r_act.f1_v_sync_end));
   assign w_field   = r_act.interlaced &&
                      in_range(r_v, r_act.f_rising_edge, r_act.f_falling_edge);

   // Output stage: counters and flags leave together, one cycle behind the counter state.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_ack <= 1'b0;
         running  <= 1'b0;
         h_count  <= 16'd0;
         v_count  <= 16'd0;
         h_sync   <= 1'b0;
         v_sync   <= 1'b0;
         h_blank  <= 1'b0;
         v_blank  <= 1'b0;
         field    <= 1'b0;
         active   <= 1'b0;
         sof      <= 1'b0;
      end else begin
         mode_ack <= w_load;
         running  <= w_running;
         if (w_running) begin
            h_count <= r_h;
            v_count <= r_v;
            h_sync  <= w_h_sync;
            v_sync  <= w_v_sync;
            h_blank <= w_h_blank;
            v_blank <= w_v_blank;
            field   <= w_field;
            active  <= !w_h_blank && !w_v_blank;
            sof     <= (r_h == 16'd0) && (r_v == 16'd0);
         end else begin
            h_count <= 16'd0;
            v_count <= 16'd0;
            h_sync  <= 1'b0;
            v_sync  <= 1'b0;
            h_blank <= 1'b0;
            v_blank <= 1'b0;
            field   <= 1'b0;
            active  <= 1'b0;
            sof     <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alt_vipitc130_is2vid_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_alt_vipitc130_is2vid_timing_gen
// Purpose  : Scoreboard bench for the video timing generator.
// Revision : 1.0
// ============================================================================
module tb_alt_vipitc130_is2vid_timing_gen;

   typedef struct packed {
      logic        il;
      logic [15:0] htot, vtot, hb, hss, hse, f2vs, f1vs, f1ve, f2ss, f2se, f1ss, f1se, fr, ff;
   } mode_t;

   typedef struct packed {
      logic [15:0] h, v;
      logic        hs, vs, hb, vb, fld, act, sof, ack;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        mode_valid = 1'b0;
   mode_t       md = '0;
   logic        mode_ack, h_sync, v_sync, h_blank, v_blank, field, active, sof, running;
   logic [15:0] h_count, v_count;

   exp_t        q[$];
   exp_t        e_mon, a_mon;
   int          checks = 0;
   int          errors = 0;
   int          ack_count = 0;
   logic        mon_en = 1'b0;
   mode_t       m1, m2, m3;

   always #5 clk = ~clk;

   alt_vipitc130_is2vid_timing_gen dut (
      .clk(clk), .rst(rst), .enable(enable), .mode_valid(mode_valid), .mode_ack(mode_ack),
      .mode_interlaced(md.il),
      .mode_h_total_minus_one(md.htot), .mode_v_total_minus_one(md.vtot),
      .mode_h_blank(md.hb), .mode_h_sync_start(md.hss), .mode_h_sync_end(md.hse),
      .mode_f2_v_start(md.f2vs), .mode_f1_v_start(md.f1vs), .mode_f1_v_end(md.f1ve),
      .mode_f2_v_sync_start(md.f2ss), .mode_f2_v_sync_end(md.f2se),
      .mode_f1_v_sync_start(md.f1ss), .mode_f1_v_sync_end(md.f1se),
      .mode_f_rising_edge(md.fr), .mode_f_falling_edge(md.ff),
      .h_count(h_count), .v_count(v_count), .h_sync(h_sync), .v_sync(v_sync),
      .h_blank(h_blank), .v_blank(v_blank), .field(field), .active(active), .sof(sof),
      .running(running)
   );

   // Monitor: every running cycle consumes one expected pixel; idle cycles must be all zero.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mode_ack) ack_count++;
         a_mon = {h_count, v_count, h_sync, v_sync, h_blank, v_blank, field, active, sof, mode_ack};
         checks++;
         if (running) begin
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pixel got h=%0d v=%0d flags=%b want none",
                        a_mon.h, a_mon.v, a_mon[7:0]);
            end else begin
               e_mon = q.pop_front();
               if (a_mon !== e_mon) begin
                  errors++;
                  $display("FAIL pixel got h=%0d v=%0d flags(hs,vs,hb,vb,fld,act,sof,ack)=%b want h=%0d v=%0d flags=%b",
                           a_mon.h, a_mon.v, a_mon[7:0], e_mon.h, e_mon.v, e_mon[7:0]);
               end
            end
         end else if (a_mon[39:1] != '0) begin
            errors++;
            $display("FAIL idle_outputs got h=%0d v=%0d flags=%b want all zero",
                     a_mon.h, a_mon.v, a_mon[7:0]);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic send_mode(input mode_t m);
      md         = m;
      mode_valid = 1'b1;
      tick(1);
      mode_valid = 1'b0;
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 10 && !mode_ack; i++) tick(1);
      checks++;
      if (!mode_ack) begin
         errors++;
         $display("FAIL mode_ack_timeout got 0 want 1");
      end
   endtask

   task automatic wait_running(input logic want, input int budget);
      for (int i = 0; i < budget && running !== want; i++) tick(1);
      checks++;
      if (running !== want) begin
         errors++;
         $display("FAIL running_wait got %b want %b", running, want);
      end
   endtask

   // Hand-written expectations per test id for every pixel of one frame.
   task automatic push_frame(input int tid, input int hn, input int vn, input logic ack_last);
      exp_t x;
      for (int v = 0; v < vn; v++) begin
         for (int h = 0; h < hn; h++) begin
            x   = '0;
            x.h = 16'(h);
            x.v = 16'(v);
            case (tid)
               1: begin
                  x.hs = (h == 1); x.hb = (h < 3); x.vb = (v == 4 || v == 5); x.vs = (v == 4);
               end
               2: begin
                  x.hb = (h < 1); x.vb = (v == 2 || v >= 4); x.vs = (v == 1 || v == 5);
                  x.fld = (v >= 3 && v <= 5);
               end
               default: begin
                  x.hb = (h < 3); x.vb = (v >= 4); x.vs = (v == 4);
               end
            endcase
            x.act = !x.hb && !x.vb;
            x.sof = (h == 0 && v == 0);
            x.ack = ack_last && (h == hn - 1) && (v == vn - 1);
            q.push_back(x);
         end
      end
   endtask

   task automatic check_drained(input string name);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL %s_queue got %0d left want 0", name, q.size());
      end
      q.delete();
   endtask

   initial begin
      // Progressive; f1/field ranges are nonzero so gating by interlaced is exercised.
      m1 = '{il: 1'b0, htot: 16'd9, vtot: 16'd5, hb: 16'd3, hss: 16'd1, hse: 16'd2,
             f2vs: 16'd4, f1vs: 16'd0, f1ve: 16'd2, f2ss: 16'd4, f2se: 16'd5,
             f1ss: 16'd0, f1se: 16'd3, fr: 16'd0, ff: 16'd3};
      // Interlaced with inverted h_sync range 6..3.
      m2 = '{il: 1'b1, htot: 16'd7, vtot: 16'd6, hb: 16'd1, hss: 16'd6, hse: 16'd3,
             f2vs: 16'd4, f1vs: 16'd2, f1ve: 16'd3, f2ss: 16'd5, f2se: 16'd6,
             f1ss: 16'd1, f1se: 16'd2, fr: 16'd3, ff: 16'd6};
      // 20-cycle lines with empty h_sync range 5..5.
      m3 = m1;
      m3.htot = 16'd19; m3.hss = 16'd5; m3.hse = 16'd5;

      tick(3);
      checks++;
      if ({running, mode_ack, h_count, v_count, sof, active} != '0) begin
         errors++;
         $display("FAIL reset_state got run=%b ack=%b h=%0d v=%0d want 0", running, mode_ack, h_count, v_count);
      end
      rst = 1'b0;
      mon_en = 1'b1;
      tick(2);

      // Progressive: two frames, enable dropped mid second frame.
      send_mode(m1); wait_ack();
      push_frame(1, 10, 6, 1'b0); push_frame(1, 10, 6, 1'b0);
      enable = 1'b1; wait_running(1'b1, 20);
      tick(70); enable = 1'b0;
      wait_running(1'b0, 200); tick(3);
      check_drained("progressive");

      // Interlaced single frame.
      send_mode(m2); wait_ack();
      push_frame(2, 8, 7, 1'b0);
      enable = 1'b1; wait_running(1'b1, 20);
      enable = 1'b0;
      wait_running(1'b0, 200); tick(3);
      check_drained("interlaced");

      // Mode change mid-frame takes effect only at frame end.
      send_mode(m1); wait_ack();
      push_frame(1, 10, 6, 1'b1); push_frame(3, 20, 6, 1'b0);
      enable = 1'b1; wait_running(1'b1, 20);
      tick(20); send_mode(m3);
      tick(60); enable = 1'b0;
      wait_running(1'b0, 400); tick(3);
      check_drained("mode_change");

      // Reset mid-line with a coincident mode_valid.
      send_mode(m1); wait_ack();
      push_frame(1, 10, 6, 1'b0);
      enable = 1'b1; wait_running(1'b1, 20);
      tick(25);
      rst = 1'b1; md = m2; mode_valid = 1'b1;
      tick(1);
      rst = 1'b0; mode_valid = 1'b0;
      checks++;
      if ({running, h_count, v_count, h_sync, v_sync, h_blank, v_blank, field, active, sof, mode_ack} != '0) begin
         errors++;
         $display("FAIL reset_midline got run=%b h=%0d v=%0d want all zero", running, h_count, v_count);
      end
      q.delete();
      tick(20);
      checks++;
      if (running !== 1'b0) begin
         errors++;
         $display("FAIL restart_without_mode got running=%b want 0", running);
      end
      push_frame(1, 10, 6, 1'b0);
      send_mode(m1); wait_ack();
      wait_running(1'b1, 20);
      enable = 1'b0;
      wait_running(1'b0, 200); tick(3);
      check_drained("after_reset");

      checks++;
      if (ack_count != 6) begin
         errors++;
         $display("FAIL ack_count got %0d want 6", ack_count);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alt_vipitc130_is2vid_timing_gen.md
ALT_VIPITC130_IS2VID_TIMING_GEN -- requirements
Module: alt_vipitc130_IS2Vid_timing_gen

Interface
REQ-001 SHALL have port clk, input, 1: single clock for all logic.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port enable, input, 1: 1 = run timing, 0 = stop at next frame end.
REQ-004 SHALL have port mode_valid, input, 1: pulse; the mode_* inputs below are valid this cycle.
REQ-005 SHALL have port mode_ack, output, 1: one-cycle pulse when pending mode is loaded into active registers.
REQ-006 SHALL have port mode_interlaced, input, 1: interlaced flag.
REQ-007 SHALL have ports mode_h_total_minus_one, mode_v_total_minus_one, input, 16 each: counter wrap values.
REQ-008 SHALL have ports mode_h_blank, mode_h_sync_start, mode_h_sync_end, input, 16 each: horizontal timing.
REQ-009 SHALL have ports mode_f2_v_start, mode_f1_v_start, mode_f1_v_end, input, 16 each: vertical blanking lines.
REQ-010 SHALL have ports mode_f2_v_sync_start, mode_f2_v_sync_end, mode_f1_v_sync_start, mode_f1_v_sync_end, input, 16 each: vertical sync lines.
REQ-011 SHALL have ports mode_f_rising_edge, mode_f_falling_edge, input, 16 each: field flag transition lines.
REQ-012 SHALL have ports h_count, v_count, output, 16 each: registered counters.
REQ-013 SHALL have ports h_sync, v_sync, h_blank, v_blank, field, output, 1 each: registered timing flags.
REQ-014 SHALL have ports active, sof, output, 1 each: active picture flag; start-of-frame pulse.
REQ-015 SHALL have port running, output, 1: state is RUNNING.

Function
REQ-016 SHALL implement states STOPPED and RUNNING.
REQ-017 STOPPED->RUNNING SHALL occur when enable=1 and the active mode is loaded; counters then start at h=0, v=0.
REQ-018 RUNNING->STOPPED SHALL occur at the frame-end cycle (h=h_total_minus_one, v=v_total_minus_one) when enable=0; counters hold 0 and all flags are 0 in STOPPED.
REQ-019 mode_valid SHALL capture all mode_* inputs into a pending register set and set a pending flag; a second mode_valid before load SHALL overwrite pending values.
REQ-020 Pending mode SHALL load into the active set only at frame end in RUNNING, or immediately in STOPPED; the pending flag SHALL clear and mode_ack SHALL pulse on the load cycle.
REQ-021 If mode_valid coincides with a load cycle, the new values SHALL be captured as pending and stay pending; the load SHALL use the previously pending values.
REQ-022 h_count SHALL increment each RUNNING cycle and wrap to 0 after h_total_minus_one; v_count SHALL increment on each h wrap and wrap to 0 after v_total_minus_one.
REQ-023 Counter compares SHALL be 16-bit unsigned; ranges [a,b) are half-open; a range with a>=b SHALL never assert.
REQ-024 h_blank SHALL be 1 when h_count < h_blank value; h_sync SHALL be 1 when h_count is in [h_sync_start, h_sync_end).
REQ-025 v_blank SHALL be 1 when v_count >= f2_v_start, or when interlaced and v_count is in [f1_v_start, f1_v_end).
REQ-026 v_sync SHALL be 1 when v_count is in [f2_v_sync_start, f2_v_sync_end), or when interlaced and v_count is in [f1_v_sync_start, f1_v_sync_end).
REQ-027 In interlaced mode, field SHALL be 1 when v_count is in [f_rising_edge, f_falling_edge); in progressive mode, field SHALL be constantly 0.
REQ-028 active SHALL equal NOT h_blank AND NOT v_blank; sof SHALL be 1 for exactly the cycle with h_count=0 and v_count=0.
REQ-029 All flag outputs SHALL be registered and aligned with the h_count/v_count values output in the same cycle (zero relative skew, one cycle after the counter state).
REQ-030 Active mode values SHALL never change mid-frame.

Reset
REQ-031 On rst=1 the block SHALL enter STOPPED, clear the pending flag and the active and pending mode registers, and drive every output to 0 on the next edge.
REQ-032 rst SHALL override every other input, including mid-frame and on a coincident mode_valid.

Verification
REQ-033 Progressive mode htot-1=9, hblank=3, hsync[1,2), vtot-1=5, f2_v_start=4, vsync[4,5), then enable=1 -> h_sync high for h=1 only; h_blank for h=0..2; v_blank on lines 4,5; sof once every 60 cycles.
REQ-034 Interlaced mode with f1_v_start=2, f1_v_end=3, f rising/falling at 3 and 6, vtot-1=6 -> v_blank on lines 2,4,5,6; field high on lines 3..5.
REQ-035 mode_valid with htot-1=19 issued mid-frame -> old timing continues to frame end; mode_ack at frame end; next frame has 20-cycle lines.
REQ-036 enable dropped mid-frame -> frame completes; running=0 after frame end; outputs 0.
REQ-037 rst asserted mid-line -> all outputs 0 next cycle; no output until a new mode_valid and enable=1.
REQ-038 h_sync_start=5 with h_sync_end=5, and h_sync_start=6 with h_sync_end=3 -> h_sync never asserts.
